// File: rtl/ultrasonic_pkg.sv
// Shared timing constants and phase type for the ultrasonic array datapath.
// Defaults describe the 10.24 MHz board clock driving 40 kHz transducers.
package ultrasonic_pkg;

  localparam int unsigned DEF_CLK_FREQ = 10_240_000;
  localparam int unsigned DEF_OUT_FREQ = 40_000;
  localparam int unsigned PERIOD       = DEF_CLK_FREQ / DEF_OUT_FREQ;
  localparam int unsigned PHASE_W      = $clog2(PERIOD);

  typedef logic [PHASE_W-1:0] phase_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for the board-to-board sync input plus a registered
// rising-edge pulse that lands together with the synchronised level rising.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic rise_q, rise_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    // meta_q has had a full cycle to settle before it reaches the detect flop
    rise_d = meta_q & ~sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      rise_q <= rise_d;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/transducer_driver.sv
// Multi-channel phased square-wave generator with double-buffered phase
// updates and master/slave board-to-board period synchronisation.
module transducer_driver
  import ultrasonic_pkg::*;
#(
  parameter  int unsigned CLK_FREQ          = DEF_CLK_FREQ,
  parameter  int unsigned OUT_FREQ          = DEF_OUT_FREQ,
  parameter  int unsigned NUM_CHANNELS      = 2,
  parameter  int unsigned MASTER            = 1,
  parameter  int unsigned SYNC_PULSE_CYCLES = 4,
  parameter  int unsigned SYNC_COMP         = 3,
  localparam int unsigned PER               = CLK_FREQ / OUT_FREQ,
  localparam int unsigned PH_W              = $clog2(PER)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_CHANNELS-1:0][PH_W-1:0]      phases,
  input  logic                                   phases_valid,
  input  logic                                   enable,
  input  logic                                   sync_in,
  output logic                                   sync_out,
  output logic [NUM_CHANNELS-1:0]                trans,
  output logic                                   phase_error,
  output logic                                   locked,
  output logic                                   period_start
);

  localparam int unsigned HALF  = PER / 2;
  localparam int unsigned TMO   = 2 * PER;
  localparam int unsigned TMR_W = $clog2(TMO + 1);

  logic [PH_W-1:0]                     cnt_q, cnt_d;
  logic [NUM_CHANNELS-1:0][PH_W-1:0]   active_q, active_d;
  logic [NUM_CHANNELS-1:0][PH_W-1:0]   shadow_q, shadow_d;
  logic                                pending_q, pending_d;
  logic [NUM_CHANNELS-1:0]             trans_q, trans_d;
  logic                                sync_out_q, sync_out_d;
  logic                                phase_error_q, phase_error_d;
  logic                                locked_q, locked_d;
  logic                                period_start_q, period_start_d;
  logic [TMR_W-1:0]                    tmr_q, tmr_d;

  logic            sync_s, sync_rise;
  logic            wrap_c, load_c, boundary_c, in_range_c;
  logic [PH_W-1:0] cnt_nat_c;

  sync_edge_detect u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (sync_in),
    .sync_o  (sync_s),
    .rise_o  (sync_rise)
  );

  // Counter, phase update path and sync/lock tracking
  always_comb begin
    wrap_c     = (cnt_q == PH_W'(PER - 1));
    load_c     = (MASTER == 0) && sync_rise;
    boundary_c = wrap_c || load_c;
    cnt_nat_c  = wrap_c ? '0 : cnt_q + PH_W'(1);
    cnt_d      = load_c ? PH_W'(SYNC_COMP) : cnt_nat_c;

    in_range_c = 1'b1;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if ((PH_W+1)'(phases[i]) >= (PH_W+1)'(PER)) in_range_c = 1'b0;
    end

    active_d      = active_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    phase_error_d = phases_valid && !in_range_c;
    if (boundary_c && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (phases_valid && in_range_c) begin
      if (boundary_c) begin
        active_d  = phases;
        pending_d = 1'b0;
      end else begin
        shadow_d  = phases;
        pending_d = 1'b1;
      end
    end

    period_start_d = (cnt_q == '0);

    tmr_d    = tmr_q;
    locked_d = locked_q;
    if (load_c) begin
      tmr_d    = '0;
      locked_d = (cnt_nat_c == PH_W'(SYNC_COMP));
    end else begin
      if (tmr_q != TMR_W'(TMO)) tmr_d = tmr_q + TMR_W'(1);
      if (tmr_q >= TMR_W'(TMO - 1)) locked_d = 1'b0;
    end

    if (MASTER != 0) begin
      locked_d   = 1'b1;
      sync_out_d = (32'(cnt_d) < SYNC_PULSE_CYCLES);
    end else begin
      sync_out_d = sync_s;
    end
  end

  // Per-channel phase compare: (cnt - phase) mod PER against half period
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    logic [PH_W:0] diff_raw, diff_mod;
    assign diff_raw   = {1'b0, cnt_q} - {1'b0, active_q[g]};
    assign diff_mod   = diff_raw[PH_W] ? diff_raw + (PH_W+1)'(PER) : diff_raw;
    assign trans_d[g] = enable && (diff_mod < (PH_W+1)'(HALF));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      active_q       <= '0;
      shadow_q       <= '0;
      pending_q      <= 1'b0;
      trans_q        <= '0;
      sync_out_q     <= 1'b0;
      phase_error_q  <= 1'b0;
      locked_q       <= 1'b0;
      period_start_q <= 1'b0;
      tmr_q          <= '0;
    end else begin
      cnt_q          <= cnt_d;
      active_q       <= active_d;
      shadow_q       <= shadow_d;
      pending_q      <= pending_d;
      trans_q        <= trans_d;
      sync_out_q     <= sync_out_d;
      phase_error_q  <= phase_error_d;
      locked_q       <= locked_d;
      period_start_q <= period_start_d;
      tmr_q          <= tmr_d;
    end
  end

  assign trans        = trans_q;
  assign sync_out     = sync_out_q;
  assign phase_error  = phase_error_q;
  assign locked       = locked_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_transducer_driver.sv
// Bench for transducer_driver: master, slave and a 200-tick master instance
// checked every cycle against a cycle-count based behavioural model.
module tb_transducer_driver;

  localparam int SC  = 3;
  localparam int SPC = 4;
  localparam int PP [3] = '{256, 256, 200};
  localparam int MS [3] = '{1, 0, 1};

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0][7:0] phases;
  logic            phases_valid;
  logic            enable;
  logic            sync_in;

  logic [1:0] trans_w [3];
  logic       sync_w  [3];
  logic       err_w   [3];
  logic       lock_w  [3];
  logic       ps_w    [3];

  always #5 clk = ~clk;

  transducer_driver #(.MASTER(1)) u_master (
    .clk(clk), .rst_n(rst_n), .phases(phases), .phases_valid(phases_valid),
    .enable(enable), .sync_in(sync_in), .sync_out(sync_w[0]), .trans(trans_w[0]),
    .phase_error(err_w[0]), .locked(lock_w[0]), .period_start(ps_w[0]));

  transducer_driver #(.MASTER(0)) u_slave (
    .clk(clk), .rst_n(rst_n), .phases(phases), .phases_valid(phases_valid),
    .enable(enable), .sync_in(sync_in), .sync_out(sync_w[1]), .trans(trans_w[1]),
    .phase_error(err_w[1]), .locked(lock_w[1]), .period_start(ps_w[1]));

  transducer_driver #(.OUT_FREQ(51_200), .MASTER(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .phases(phases), .phases_valid(phases_valid),
    .enable(enable), .sync_in(sync_in), .sync_out(sync_w[2]), .trans(trans_w[2]),
    .phase_error(err_w[2]), .locked(lock_w[2]), .period_start(ps_w[2]));

  // Behavioural model state: counter position, phase tables, expected outputs
  int       m_cnt  [3];
  int       m_act  [3][2];
  int       m_shd  [3][2];
  bit       m_pend [3];
  int       m_last [3];
  bit [1:0] e_trans[3];
  bit       e_ps   [3];
  bit       e_sync [3];
  bit       e_err  [3];
  bit       e_lock [3];
  bit       sin_h  [0:8191];

  int vecs = 0;
  int errs = 0;
  int n    = 0;
  int seg  = 0;
  bit en_state = 1'b1;

  task automatic chk(input string nm, input int inst, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s inst%0d seg%0d n=%0d: got %0h expected %0h", nm, inst, seg, n, got, exp);
    end
  endtask

  function automatic bit samp(input int k);
    if (k < 1) return 1'b0;
    return sin_h[k];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_pend[i] = 0; m_last[i] = 0;
      for (int c = 0; c < 2; c++) begin m_act[i][c] = 0; m_shd[i][c] = 0; end
      e_trans[i] = 2'b00; e_ps[i] = 0; e_sync[i] = 0; e_err[i] = 0; e_lock[i] = 0;
    end
  endtask

  // Advance every instance model across posedge k using the driven inputs
  task automatic model_step(input int k);
    sin_h[k] = sync_in;
    for (int i = 0; i < 3; i++) begin
      int p, nat;
      bit ld, bnd, ok;
      p  = PP[i];
      ld = (MS[i] == 0) && samp(k - 2) && !samp(k - 3);
      for (int c = 0; c < 2; c++)
        e_trans[i][c] = enable && (((m_cnt[i] - m_act[i][c] + p) % p) < p / 2);
      e_ps[i]  = (m_cnt[i] == 0);
      bnd      = ld || (m_cnt[i] == p - 1);
      ok       = (int'(phases[0]) < p) && (int'(phases[1]) < p);
      e_err[i] = phases_valid && !ok;
      if (phases_valid && ok && bnd) begin
        m_act[i][0] = int'(phases[0]); m_act[i][1] = int'(phases[1]); m_pend[i] = 0;
      end else begin
        if (bnd && m_pend[i]) begin
          m_act[i][0] = m_shd[i][0]; m_act[i][1] = m_shd[i][1]; m_pend[i] = 0;
        end
        if (phases_valid && ok) begin
          m_shd[i][0] = int'(phases[0]); m_shd[i][1] = int'(phases[1]); m_pend[i] = 1;
        end
      end
      nat = (m_cnt[i] + 1) % p;
      if (ld) begin
        e_lock[i] = (nat == SC);
        m_last[i] = k;
        m_cnt[i]  = SC;
      end else begin
        m_cnt[i] = nat;
        if (MS[i] != 0) e_lock[i] = 1;
        else if (k - m_last[i] >= 2 * p) e_lock[i] = 0;
      end
      e_sync[i] = (MS[i] != 0) ? (m_cnt[i] < SPC) : samp(k - 2);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk("trans",        i, 32'(trans_w[i]), 32'(e_trans[i]));
      chk("period_start", i, 32'(ps_w[i]),    32'(e_ps[i]));
      chk("sync_out",     i, 32'(sync_w[i]),  32'(e_sync[i]));
      chk("phase_error",  i, 32'(err_w[i]),   32'(e_err[i]));
      chk("locked",       i, 32'(lock_w[i]),  32'(e_lock[i]));
    end
  endtask

  task automatic check_zero(input string nm);
    for (int i = 0; i < 3; i++) begin
      chk({nm, "_trans"}, i, 32'(trans_w[i]), 32'(0));
      chk({nm, "_out"},   i, 32'({sync_w[i], err_w[i], lock_w[i], ps_w[i]}), 32'(0));
    end
  endtask

  task automatic rand_update();
    phases_valid = ($urandom_range(0, 49) == 0);
    if (phases_valid) begin
      phases[0] = 8'($urandom_range(0, 255));
      phases[1] = 8'($urandom_range(0, 255));
    end
    if ($urandom_range(0, 39) == 0) en_state = ~en_state;
    enable = en_state;
  endtask

  task automatic drive(input int k);
    phases_valid = 1'b0;
    enable       = 1'b1;
    if (seg == 0) begin
      if (k == 523)  begin phases_valid = 1'b1; phases[0] = 8'd64;  phases[1] = 8'd128; end
      if (k == 1024) begin phases_valid = 1'b1; phases[0] = 8'd32;  phases[1] = 8'd32;  end
      if (k == 1100) begin phases_valid = 1'b1; phases[0] = 8'd250; phases[1] = 8'd5;   end
      if (k == 1150) enable = 1'b0;
      if (k >= 1200) rand_update();
      if (k >= 100 && k < 2000)  sync_in = (((k - 100) % 256) < 4);
      else if (k >= 2600)        sync_in = sync_in ^ ($urandom_range(0, 31) == 0);
      else                       sync_in = 1'b0;
    end else begin
      rand_update();
      sync_in = (k >= 37 && k < 900) ? (((k - 37) % 256) < 4) : 1'b0;
    end
  endtask

  // Hand-computed expectations that pin the model to the intended behaviour
  task automatic pins();
    if (seg != 0) return;
    case (n)
      1:    begin chk("pin_rise_cnt0", 0, 32'(trans_w[0]), 32'h3);
                  chk("pin_ps_first",  0, 32'(ps_w[0]),    32'h1);
                  chk("pin_locked_m",  0, 32'(lock_w[0]),  32'h1); end
      129:  chk("pin_half_low",    0, 32'(trans_w[0]), 32'h0);
      257:  chk("pin_ps_period",   0, 32'(ps_w[0]),    32'h1);
      259:  chk("pin_sync_hi",     0, 32'(sync_w[0]),  32'h1);
      260:  chk("pin_sync_lo",     0, 32'(sync_w[0]),  32'h0);
      300:  chk("pin_slave_unlk",  1, 32'(lock_w[1]),  32'h0);
      356:  chk("pin_slave_ps",    1, 32'(ps_w[1]),    32'h1);
      360:  chk("pin_slave_lock",  1, 32'(lock_w[1]),  32'h1);
      832:  chk("pin_ph64_pre",    0, 32'(trans_w[0]), 32'h0);
      833:  chk("pin_ph64_rise",   0, 32'(trans_w[0]), 32'h1);
      897:  chk("pin_ph128_rise",  0, 32'(trans_w[0]), 32'h3);
      1056: chk("pin_byp_pre",     0, 32'(trans_w[0]), 32'h0);
      1057: chk("pin_byp_rise",    0, 32'(trans_w[0]), 32'h3);
      1100: begin chk("pin_reject",  2, 32'(err_w[2]), 32'h1);
                  chk("pin_accept",  0, 32'(err_w[0]), 32'h0); end
      1101: chk("pin_reject_end",  2, 32'(err_w[2]),   32'h0);
      1150: chk("pin_enable_off",  0, 32'(trans_w[0]), 32'h0);
      2405: chk("pin_lock_hold",   1, 32'(lock_w[1]),  32'h1);
      2406: chk("pin_lock_drop",   1, 32'(lock_w[1]),  32'h0);
      default: ;
    endcase
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      n++;
      drive(n);
      model_step(n);
      @(negedge clk);
      compare_all();
      pins();
    end
  endtask

  initial begin
    rst_n = 1'b0; phases = '0; phases_valid = 1'b0; enable = 1'b1; sync_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    compare_all();
    run(3000);

    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    seg = 1; n = 0;
    rst_n = 1'b1;
    run(1500);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/transducer_driver.md
# transducer_driver

Multi-channel phased square-wave generator for the ultrasonic array: produces one OUT_FREQ drive signal per transducer, each delayed by a programmable phase. It replaces the constant-zero `trans` and `sync_out` placeholders in the top level and consumes the `phases` vector produced by `receiver`. Phase updates are double-buffered and take effect only on a period boundary. A MASTER parameter selects between generating the board-to-board sync pulse and locking to it.

## Interface
- CLK_FREQ, 10_240_000: clock frequency, Hz
- OUT_FREQ, 40_000: drive frequency, Hz; PERIOD = CLK_FREQ/OUT_FREQ (256), must be even and ≥ 4
- NUM_CHANNELS, 2: number of transducer outputs
- PHASE_W, $clog2(PERIOD): phase field width (8)
- MASTER, 1: 1 = generate sync_out; 0 = lock counter to sync_in
- SYNC_PULSE_CYCLES, 4: master sync pulse width, cycles
- SYNC_COMP, 3: counter load value on a detected sync edge (synchroniser + detect latency)

Ports:
- clk  in  1  system clock (PLL output)
- rst_n  in  1  asynchronous active-low reset
- phases  in  [NUM_CHANNELS][PHASE_W]  requested per-channel phase, in clock ticks
- phases_valid  in  1  one-cycle strobe; captures `phases`
- enable  in  1  drive enable; 0 forces all `trans` low
- sync_in  in  1  asynchronous sync from the upstream board (slave only)
- sync_out  out  1  master: sync pulse; slave: registered copy of the synchronised `sync_in` for daisy-chaining
- trans  out  NUM_CHANNELS  transducer drive outputs
- phase_error  out  1  one-cycle pulse: an update was rejected
- locked  out  1  counter aligned to the sync reference
- period_start  out  1  one-cycle pulse when cnt == 0

## Operation
- Free-running counter `cnt` counts 0…PERIOD-1 and wraps to 0. A wrap, or a slave sync load, is a **boundary**.
- **Update**: on phases_valid, if every channel is < PERIOD, all values go to the shadow register and `pending` is set. If any channel is ≥ PERIOD, the whole update is dropped, the shadow is unchanged, and phase_error pulses.
- At a boundary with `pending` set, active ← shadow and `pending` is cleared.
- If phases_valid coincides with a boundary, the new values go directly to active; this bypasses the shadow.
- **Output**: trans[i] = enable && ((cnt − active[i]) mod PERIOD) < PERIOD/2.
  - The subtraction is done at PHASE_W+1 bits, with PERIOD added back when the result is negative.
  - Phase 0 gives a rising edge at cnt 0. Phase PERIOD/2 is the inverse of phase 0.
- **Master**: sync_out is high for SYNC_PULSE_CYCLES cycles, starting on the cycle where cnt == 0. locked is 1 from the first cycle after reset release.
- **Slave**:
  - sync_in passes through a 2-flop synchroniser and a rising-edge detect.
  - On an edge, cnt ← SYNC_COMP. If cnt would already have been SYNC_COMP, locked ← 1; otherwise locked ← 0.
  - No edge for 2·PERIOD cycles clears locked.
  - sync_out = the synchronised sync_in, delayed by one register.
- enable affects only trans. The counter, the update path and sync keep running while enable is 0.

## Timing
- Reset values: cnt 0, active 0, shadow 0, pending 0, trans 0, sync_out 0, phase_error 0, locked 0, period_start 0.
- trans and period_start are registered: the value at cycle k+1 is derived from cnt at cycle k.
- enable deasserted at cycle k → trans all 0 at k+1.
- phases_valid at cycle k → shadow valid at k+1. It is applied at the next boundary; trans reflects it one cycle after that boundary.
- Slave latency: sync_in rising edge → cnt load after 3 clk edges (2 synchroniser flops + edge register), hence SYNC_COMP = 3.
- A sync edge arriving mid-period truncates or extends that period. No glitch shorter than one cycle may appear on trans.
- Reset asserted mid-operation clears all state immediately. The first period after release starts at cnt 0 with all phases 0.

## Structure
- Package `ultrasonic_pkg` holds:
  - `PERIOD`, `PHASE_W` localparams derived from CLK_FREQ/OUT_FREQ
  - `phase_t` typedef (logic [PHASE_W-1:0]), shared with `receiver`
- One sub-module: `sync_edge_detect` (2-flop synchroniser + registered rising-edge pulse, async active-low reset).
- The per-channel compare is a generate loop; no further hierarchy.

## Test plan
- **Reset and defaults:** reset, enable=1, phases 0 → trans[0] = trans[1] rise at cnt 0, 128 cycles high / 128 low. period_start pulses every 256 cycles.
- **Double-buffered update:** phases = {64, 128} strobed at cnt 10 → no change until the wrap. Afterwards trans[0] rises at cnt 64 and trans[1] is the inverse of a phase-0 wave.
- **Boundary bypass and reject:** strobe {32, 32} exactly at cnt 255 → applied in the next period. Strobe {300, 5} with PHASE_W widened in the bench (or {256, 5} forced) → phase_error pulses once and active is unchanged.
- **Master sync:** MASTER=1 → sync_out high for 4 cycles starting at cnt 0, every 256 cycles. locked = 1.
- **Slave lock:** MASTER=0; drive sync_in edges every 256 cycles, the first one offset by 100 → first edge corrects cnt and locked stays 0; second edge → locked = 1. Stop sync_in → locked drops after 512 cycles.
- **Enable and mid-run reset:** enable=0 at an arbitrary cycle → trans 0 on the next cycle while cnt continues. Assert rst_n low mid-period → all outputs 0 immediately.
